// File: rtl/bitstream_packer.sv
// Byte FIFO packer: accepts 0-3 bitstream bytes plus an optional final byte per cycle and
// drains them as a single-byte valid/ready stream. Optional macro: BITSTREAM_PACKER_COUNT_EN.
module bitstream_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   top_clk,
  input  logic                   top_reset,
  input  logic [DATA_WIDTH-1:0]  in_bit_1,
  input  logic [DATA_WIDTH-1:0]  in_bit_2,
  input  logic [DATA_WIDTH-1:0]  in_bit_3,
  input  logic [2:0]             in_flag,
  input  logic [DATA_WIDTH-1:0]  in_last_bit,
  input  logic                   in_flag_last,
  input  logic                   in_error,
  output logic [DATA_WIDTH-1:0]  out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [ADDR_WIDTH:0]    fifo_level,
  output logic                   overflow,
  output logic                   error_sticky,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  function automatic logic [1:0] sat_count(input logic [2:0] f);
    return (f > 3'd3) ? 2'd3 : f[1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [DATA_WIDTH:0]     mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]     level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic                    error_q, error_d;

  logic [1:0]              n_grp;
  logic [2:0]              n_wr;
  logic                    fits, wr_en, drop, pop;
  logic [DATA_WIDTH:0]     head;
  logic [DATA_WIDTH-1:0]   grp [4];
  logic [DATA_WIDTH:0]     ent [4];

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    grp[0] = in_bit_1;
    grp[1] = in_bit_2;
    grp[2] = in_bit_3;
    grp[3] = in_last_bit;
    n_grp  = sat_count(in_flag);
    n_wr   = {1'b0, n_grp} + {2'b00, in_flag_last};
    // Entries past the group bytes carry the final byte with its last tag.
    for (int k = 0; k < 4; k++) begin
      if (k < int'(n_grp)) ent[k] = {1'b0, grp[k]};
      else                 ent[k] = {1'b1, in_last_bit};
    end
  end

  always_comb begin
    out_valid = (state_q != DONE) && (level_q != '0);
    out_byte  = out_valid ? head[DATA_WIDTH-1:0] : '0;
    out_last  = out_valid & head[DATA_WIDTH];
    pop       = out_valid && out_ready;

    // Space is judged against the level before this cycle's pop.
    fits  = ({2'b00, level_q} + (ADDR_WIDTH + 3)'(n_wr)) <= (ADDR_WIDTH + 3)'(FIFO_DEPTH);
    wr_en = (state_q == RUN) && fits && (n_wr != 3'd0);
    drop  = (state_q == RUN) && !fits;

    level_d    = level_q + (wr_en ? (ADDR_WIDTH + 1)'(n_wr) : '0) - (ADDR_WIDTH + 1)'(pop);
    wr_ptr_d   = wr_ptr_q + (wr_en ? ADDR_WIDTH'(n_wr) : '0);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(pop);
    overflow_d = overflow_q | drop;
    error_d    = error_q | in_error;

    state_d = state_q;
    unique case (state_q)
      RUN:     if (in_flag_last) state_d = DRAIN;
      DRAIN:   if ((pop && head[DATA_WIDTH]) || (level_d == '0)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge top_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en && (k < int'(n_wr))) mem_q[wr_ptr_q + ADDR_WIDTH'(k)] <= ent[k];
    end
  end

  always_ff @(posedge top_clk) begin
    if (!top_reset) begin
      state_q    <= RUN;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign fifo_level   = level_q;
  assign overflow     = overflow_q;
  assign error_sticky = error_q;
  assign done         = (state_q == DONE);

`ifdef BITSTREAM_PACKER_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // pop is never asserted in DONE, so the count freezes there.
  assign count_d = count_q + COUNT_WIDTH'(pop);

  always_ff @(posedge top_clk) begin
    if (!top_reset) count_q <= '0;
    else            count_q <= count_d;
  end

  assign byte_count = count_q;
`else
  assign byte_count = '0;
`endif

endmodule

// File: doc/bitstream_packer.md
Name: bitstream_packer

Overview:
- Downstream of the carry-propagation output register stage.
- Each cycle it accepts 0-3 resolved bitstream bytes plus an optional final byte, and stores them in order in a byte FIFO.
- It drains the FIFO as a single-byte valid/ready stream toward the memory/host interface.
- Upstream cannot be stalled, so a FIFO overrun is reported as a sticky flag rather than applied as backpressure.

Parameters:
- DATA_WIDTH, 8, bitstream byte width.
- FIFO_DEPTH, 16, byte entries; power of two, >= 8.
- ADDR_WIDTH, 4, log2(FIFO_DEPTH).
- COUNT_WIDTH, 32, width of the delivered-byte counter.

Ports:
- top_clk  in  1  clock.
- top_reset  in  1  reset; synchronous and active-low, sampled on rising edge of top_clk.
- in_bit_1  in  DATA_WIDTH  first byte of the group, oldest.
- in_bit_2  in  DATA_WIDTH  second byte.
- in_bit_3  in  DATA_WIDTH  third byte.
- in_flag  in  3  number of valid bytes in bit_1..bit_3 (0-3); values 4-7 saturate to 3.
- in_last_bit  in  DATA_WIDTH  final stream byte; valid only when in_flag_last=1.
- in_flag_last  in  1  end of stream; in_last_bit is appended after the in_flag bytes of the same cycle.
- in_error  in  1  confirmed-error indication from the upstream stage.
- out_byte  out  DATA_WIDTH  FIFO head byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts out_byte.
- out_last  out  1  out_byte is the final stream byte.
- fifo_level  out  ADDR_WIDTH+1  occupied entries.
- overflow  out  1  sticky: a group was dropped.
- error_sticky  out  1  sticky OR of in_error.
- done  out  1  final byte delivered, or stream drained.
- byte_count  out  COUNT_WIDTH  bytes handshaked on the output.

Behaviour:
Reset (top_reset=0 at a clock edge):
- FIFO emptied, state RUN.
- All outputs 0: out_byte, out_valid, out_last, fifo_level, overflow, error_sticky, done, byte_count.
- Reset asserted mid-stream discards FIFO contents; no partial output.

Storage:
- FIFO entries are DATA_WIDTH+1 bits: the byte plus a last tag.
- Read pointer and write pointer are ADDR_WIDTH bits and wrap modulo FIFO_DEPTH.

Write side:
- n = sat(in_flag) + in_flag_last.
- Writes happen only in state RUN.
- If level_q + n <= FIFO_DEPTH (level_q = level before this cycle's pop), write n entries in order bit_1, bit_2, bit_3, last_bit.
- The tag is set only on the in_last_bit entry.
- Otherwise drop the whole group and set overflow; it stays set until reset.
- A pop in the same cycle does not free space for that cycle's write.

Read side:
- out_valid = (fifo_level != 0).
- out_byte and out_last reflect the head entry.
- Pop when out_valid && out_ready.
- A byte written at edge N is visible at the output after edge N (1-cycle latency) if the FIFO was empty.
- out_byte is held stable while out_valid && !out_ready.

fifo_level:
- Updates each cycle by +n_written - pop.
- Simultaneous write and pop are both applied.

State machine:
- RUN -> DRAIN on in_flag_last=1, whether or not the group fit.
- DRAIN: all in_* ignored except in_error; the FIFO continues draining.
- DRAIN -> DONE when a pop of a tagged entry occurs, or when fifo_level becomes 0.
- DONE: done=1, out_valid=0; the block stays here until reset.

Sticky flags:
- error_sticky sets on any cycle with in_error=1, in any state.

Optional Feature:
- Macro: BITSTREAM_PACKER_COUNT_EN.
- Defined: byte_count increments by 1 on every output handshake and wraps modulo 2^COUNT_WIDTH. It is frozen in DONE.
- Undefined: no counter logic; byte_count is tied to 0.

Test Plan:
- Reset, then in_flag=3, bytes A1/B2/C3, out_ready=1 -> A1, B2, C3 on three consecutive cycles starting one cycle later; fifo_level goes 3, 2, 1, 0; byte_count=3.
- in_flag=2 (0x10, 0x20) with in_flag_last=1, in_last_bit=0x30 -> bytes 0x10, 0x20, 0x30; out_last=1 only on 0x30; done=1 the cycle after 0x30 handshakes. A later in_flag=3 is ignored.
- out_ready=0, three cycles of in_flag=3 -> fifo_level=9, out_byte stable at the first byte. Then in_flag=3 for three more cycles: levels 12, 15, and the third group (15+3>16) is dropped with overflow=1, level stays 15.
- FIFO at 14, out_ready=1, in_flag=3 in the same cycle -> group dropped (14+3>16), overflow=1, level becomes 13.
- in_error pulse for 1 cycle at any point -> error_sticky=1 until top_reset=0. top_reset=0 mid-drain with level=5 -> all outputs 0 the next cycle.
- Pointer wrap: stream 40 bytes with out_ready=1 -> order preserved across the wrap, with the last=1 tag on byte 40.
